// File: rtl/player_button_decoder_if.sv
// Player button bundle: controller-side request/speed, raw board buttons and the
// decoded colour result flowing back to the controller.
interface player_button_decoder_if #(
    parameter int COLOR_CODEFY_W = 2
);
    logic                      enable;
    logic                      speed;
    logic                      btn_red;
    logic                      btn_green;
    logic                      btn_blue;
    logic                      btn_yellow;
    logic [COLOR_CODEFY_W-1:0] color_out;
    logic                      press_valid;
    logic                      timeout;
    logic                      busy;

    modport master (
        output enable, speed, btn_red, btn_green, btn_blue, btn_yellow,
        input  color_out, press_valid, timeout, busy
    );

    modport slave (
        input  enable, speed, btn_red, btn_green, btn_blue, btn_yellow,
        output color_out, press_valid, timeout, busy
    );
endinterface

// File: rtl/player_button_decoder.sv
// Genius/Simon player front end: synchronises and debounces the four colour
// buttons, emits one validated colour code per press and flags slow responses.
module player_button_decoder #(
    parameter int COLOR_CODEFY_W  = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_SLOW    = 50000000,
    parameter int TIMEOUT_FAST    = 25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    player_button_decoder_if.slave  bus
);

    localparam int TIMER_MAX = (TIMEOUT_SLOW > TIMEOUT_FAST) ? TIMEOUT_SLOW : TIMEOUT_FAST;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam int DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [TIMER_W-1:0] SLOW_LAST = TIMER_W'(TIMEOUT_SLOW - 1);
    localparam logic [TIMER_W-1:0] FAST_LAST = TIMER_W'(TIMEOUT_FAST - 1);
    localparam logic [TIMER_W-1:0] TIMER_SAT = TIMER_W'(TIMER_MAX);
    localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_SAT   = DEB_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RELEASE,
        ARMED,
        DEBOUNCE
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                sync1_q, sync1_d;
    logic [3:0]                sync2_q, sync2_d;
    logic [DEB_W-1:0]          deb_cnt_q, deb_cnt_d;
    logic [TIMER_W-1:0]        timer_q, timer_d;
    logic [1:0]                latched_q, latched_d;
    logic [COLOR_CODEFY_W-1:0] color_q, color_d;
    logic                      press_valid_q, press_valid_d;
    logic                      timeout_q, timeout_d;

    logic                      s_none;
    logic                      s_single;
    logic [1:0]                s_index;
    logic                      s_matches_latched;
    logic                      timer_expired;
    logic [TIMER_W-1:0]        timer_inc;
    logic [DEB_W-1:0]          deb_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_cnt_q     <= '0;
            timer_q       <= '0;
            latched_q     <= '0;
            color_q       <= '0;
            press_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            deb_cnt_q     <= deb_cnt_d;
            timer_q       <= timer_d;
            latched_q     <= latched_d;
            color_q       <= color_d;
            press_valid_q <= press_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    // Bit order of the synchronised vector matches the colour code.
    always_comb begin
        s_single = 1'b1;
        s_index  = 2'd0;
        case (sync2_q)
            4'b0001: s_index = 2'd0;
            4'b0010: s_index = 2'd1;
            4'b0100: s_index = 2'd2;
            4'b1000: s_index = 2'd3;
            default: s_single = 1'b0;
        endcase
    end

    assign s_none            = (sync2_q == 4'b0000);
    assign s_matches_latched = (sync2_q == (4'b0001 << latched_q));
    assign timer_expired     = (timer_q >= (bus.speed ? FAST_LAST : SLOW_LAST));
    assign timer_inc         = (timer_q == TIMER_SAT) ? timer_q : timer_q + TIMER_W'(1);
    assign deb_inc           = (deb_cnt_q == DEB_SAT) ? deb_cnt_q : deb_cnt_q + DEB_W'(1);

    always_comb begin
        state_d       = state_q;
        sync1_d       = {bus.btn_yellow, bus.btn_blue, bus.btn_green, bus.btn_red};
        sync2_d       = sync1_q;
        deb_cnt_d     = deb_cnt_q;
        timer_d       = timer_q;
        latched_d     = latched_q;
        color_d       = color_q;
        press_valid_d = 1'b0;
        timeout_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d   = WAIT_RELEASE;
                    deb_cnt_d = '0;
                end
            end

            // A button still held from the previous step must be released first.
            WAIT_RELEASE: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (!s_none) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = ARMED;
                    timer_d = '0;
                end else begin
                    deb_cnt_d = deb_inc;
                end
            end

            ARMED: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_inc;
                    if (timer_expired) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else if (s_single) begin
                        latched_d = s_index;
                        deb_cnt_d = '0;
                        state_d   = DEBOUNCE;
                    end
                end
            end

            // Acceptance is checked before expiry so a press landing on the last cycle wins.
            DEBOUNCE: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_inc;
                    if (s_matches_latched && (deb_cnt_q == DEB_LAST)) begin
                        color_d       = COLOR_CODEFY_W'(latched_q);
                        press_valid_d = 1'b1;
                        deb_cnt_d     = '0;
                        state_d       = WAIT_RELEASE;
                    end else if (timer_expired) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else if (s_matches_latched) begin
                        deb_cnt_d = deb_inc;
                    end else begin
                        state_d = ARMED;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.color_out   = color_q;
    assign bus.press_valid = press_valid_q;
    assign bus.timeout     = timeout_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: doc/player_button_decoder.md
Name: player_button_decoder

Overview:
- Player-side input front end for the Genius/Simon game. This is the counterpart of the LED sequence display: the controller shows colours on the LEDs, and this block turns the four raw colour buttons into validated colour codes.
- It synchronises and debounces the buttons and encodes a single pressed button into a COLOR_CODEFY_W code with a one-cycle valid strobe.
- It enforces a speed-dependent response timeout.
- Sits between the board buttons and the player_input register/controller.

Parameters:
- COLOR_CODEFY_W, 2, width of the colour code (red=0, green=1, blue=2, yellow=3).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required for a press or a release; must be at least 2.
- TIMEOUT_SLOW, 50000000, response window in cycles when speed=0.
- TIMEOUT_FAST, 25000000, response window in cycles when speed=1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  controller is waiting for player input.
- speed  in  1  registered speed setting (1=fast).
- btn_red  in  1  raw asynchronous button, active-high.
- btn_green  in  1  raw asynchronous button, active-high.
- btn_blue  in  1  raw asynchronous button, active-high.
- btn_yellow  in  1  raw asynchronous button, active-high.
- color_out  out  COLOR_CODEFY_W  last accepted colour code.
- press_valid  out  1  one-cycle pulse: color_out has just been updated with a new press.
- timeout  out  1  one-cycle pulse: response window expired with no press.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, all counters 0, synchroniser flops 0.
- Synchronisation: each button passes through a 2-flop synchroniser. Only the synchronised vector s[3:0] is used internally. "single" means exactly one bit of s is set; "none" means s==0.
- IDLE: outputs quiet. On enable=1, go to WAIT_RELEASE.
- WAIT_RELEASE:
  - The debounce counter increments while none, and clears whenever any bit of s is set.
  - When the counter reaches DEBOUNCE_CYCLES-1 with none, go to ARMED and clear the timeout timer.
  - This guarantees a button held from a previous step is never reused.
- ARMED:
  - The timeout timer increments every cycle.
  - On single, latch the pressed index and go to DEBOUNCE with the debounce counter at 0.
  - Multiple simultaneous buttons are ignored; stay in ARMED.
- DEBOUNCE:
  - The timer keeps running.
  - If s still equals the latched single button, the counter increments.
  - If s changes in any way, go back to ARMED with no pulse; the timer is not cleared.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the button unchanged, register color_out = encoded index and assert press_valid for one cycle, then go to WAIT_RELEASE.
- Press latency: a clean raw press held from cycle 0 gives press_valid high in cycle 3+DEBOUNCE_CYCLES.
- Timeout:
  - Selected limit is TIMEOUT_FAST if speed=1, otherwise TIMEOUT_SLOW. speed is sampled every cycle; the controller keeps it static during play.
  - When the timer reaches limit-1 in ARMED or DEBOUNCE, assert timeout for one cycle and go to IDLE.
  - If press acceptance and timer expiry fall in the same cycle, the press wins: press_valid=1, timeout=0.
- enable=0 in any non-IDLE state: go to IDLE next cycle, no pulse, color_out holds its value.
- press_valid and timeout are never high in the same cycle. Each is high for exactly one cycle per event.
- Counter widths: $clog2(max(TIMEOUT_SLOW, TIMEOUT_FAST)+1) and $clog2(DEBOUNCE_CYCLES+1). Counters never wrap; they saturate at their limit.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Any in-progress press is discarded.

Test Plan:
1. DEBOUNCE_CYCLES=4, enable=1, all buttons released, then btn_blue held -> press_valid single pulse 7 cycles after the raw edge, color_out=2. No second pulse while held; a second press requires release for 4 stable cycles.
2. btn_green bounces 1,0,1 at 1-cycle spacing, then holds stable -> exactly one press_valid with color_out=1. No pulse during the bounce.
3. btn_red and btn_yellow pressed together, then btn_red released -> no pulse while both are held; one pulse with color_out=3 after yellow has been alone for 4 stable cycles.
4. TIMEOUT_FAST=20, TIMEOUT_SLOW=40, speed=1, no buttons pressed -> timeout pulse on the 20th cycle in ARMED, then busy=0. Repeat with speed=0 -> pulse on the 40th cycle.
5. btn_yellow already held when enable rises -> no press until it is released for 4 cycles and pressed again; then color_out=3.
6. enable dropped, and separately rst asserted, during DEBOUNCE -> no press_valid, busy=0 the next cycle. After rst, color_out=0.
